// File: rtl/vga_timing_sprite.sv
// VGA timing generator with a monochrome bitmap sprite overlay; every output is registered on the pixel tick.
// Build option: define VGA_SPRITE_SCALE2_EN to draw the sprite at 2x scale.
module vga_timing_sprite #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   SPR_W    = 80,
    parameter int   SPR_H    = 28,
    parameter int   CW       = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CW-1:0]            spr_x,
    input  logic [CW-1:0]            spr_y,
    input  logic                     bmap_we,
    input  logic [$clog2(SPR_H)-1:0] bmap_addr,
    input  logic [SPR_W-1:0]         bmap_data,
    output logic                     h_sync,
    output logic                     v_sync,
    output logic                     active,
    output logic [CW-1:0]            pix_x,
    output logic [CW-1:0]            pix_y,
    output logic                     pixel_on,
    output logic                     frame_start
);
`ifdef VGA_SPRITE_SCALE2_EN
    localparam int SCALE_SH = 1;
`else
    localparam int SCALE_SH = 0;
`endif
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW  = $clog2(SPR_H);
    localparam int CXW = $clog2(SPR_W);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] HIT_W    = CW'(SPR_W << SCALE_SH);
    localparam logic [CW-1:0] HIT_H    = CW'(SPR_H << SCALE_SH);

    logic [SPR_W-1:0] ram_q [SPR_H];

    logic [DW-1:0]    div_q, div_d;
    logic [CW-1:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CW-1:0]    sx_q, sx_d, sy_q, sy_d;
    logic             h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic             active_q, active_d, pixel_on_q, pixel_on_d;
    logic             frame_start_q, frame_start_d;
    logic [CW-1:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    logic             tick, frame_first, act_now, in_x, in_y;
    logic [CW-1:0]    sx_cur, sy_cur, dx, dy;
    logic [AW-1:0]    row_idx;
    logic [CXW-1:0]   col_idx;
    logic [SPR_W-1:0] row_rd;

    // Rows are writable at any time; a same-clk read of the row being written sees the old data.
    always_ff @(posedge clk) begin
        if (bmap_we) begin
            ram_q[bmap_addr] <= bmap_data;
        end
    end

    always_comb begin
        tick        = (div_q == DIV_LAST);
        frame_first = (hcnt_q == '0) && (vcnt_q == '0);
        // The first pixel of a frame already uses the position being latched on that tick.
        sx_cur      = frame_first ? spr_x : sx_q;
        sy_cur      = frame_first ? spr_y : sy_q;
        dx          = hcnt_q - sx_cur;
        dy          = vcnt_q - sy_cur;
        in_x        = (hcnt_q >= sx_cur) && (dx < HIT_W);
        in_y        = (vcnt_q >= sy_cur) && (dy < HIT_H);
        row_idx     = AW'(dy >> SCALE_SH);
        col_idx     = CXW'(dx >> SCALE_SH);
        row_rd      = ram_q[row_idx];
        act_now     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

        div_d         = tick ? '0 : div_q + 1'b1;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        active_d      = active_q;
        pixel_on_d    = pixel_on_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;

        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            if (frame_first) begin
                sx_d = spr_x;
                sy_d = spr_y;
            end
            h_sync_d      = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? H_POL : ~H_POL;
            v_sync_d      = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? V_POL : ~V_POL;
            active_d      = act_now;
            pixel_on_d    = act_now && in_x && in_y && row_rd[col_idx];
            pix_x_d       = hcnt_q;
            pix_y_d       = vcnt_q;
            frame_start_d = frame_first;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            h_sync_q      <= ~H_POL;
            v_sync_q      <= ~V_POL;
            active_q      <= 1'b0;
            pixel_on_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            active_q      <= active_d;
            pixel_on_q    <= pixel_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign active      = active_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pixel_on    = pixel_on_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_sprite.sv
// Bench for vga_timing_sprite: a reduced-size raster (80x55 totals) on two instances, CLK_DIV=1 and CLK_DIV=4.
module tb_vga_timing_sprite;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 80
    localparam int VT = VA + VF + VS + VB;   // 55
    localparam int FR = HT * VT;             // 4400 clks per frame at CLK_DIV=1
    localparam int SW = 8, SH = 4, CWB = 8;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       pon;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] spr_x = '0, spr_y = '0;
    logic       bmap_we = 1'b0;
    logic [1:0] bmap_addr = '0;
    logic [7:0] bmap_data = '0;

    logic       o1_hs, o1_vs, o1_act, o1_pon, o1_fs;
    logic [7:0] o1_x, o1_y;
    logic       o4_hs, o4_vs, o4_act, o4_pon, o4_fs;
    logic [7:0] o4_x, o4_y;

    int errors = 0;
    int checks = 0;

    exp_t       sb_q[$];
    int         m_h = 0, m_v = 0, m_sx = 0, m_sy = 0;
    logic [SW-1:0] m_ram [SH];

    always #5 clk = ~clk;

    vga_timing_sprite #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .SPR_W(SW), .SPR_H(SH), .CW(CWB)
    ) u_div1 (
        .clk(clk), .rst_n(rst_n), .spr_x(spr_x), .spr_y(spr_y),
        .bmap_we(bmap_we), .bmap_addr(bmap_addr), .bmap_data(bmap_data),
        .h_sync(o1_hs), .v_sync(o1_vs), .active(o1_act), .pix_x(o1_x), .pix_y(o1_y),
        .pixel_on(o1_pon), .frame_start(o1_fs)
    );

    vga_timing_sprite #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .SPR_W(SW), .SPR_H(SH), .CW(CWB)
    ) u_div4 (
        .clk(clk), .rst_n(rst_n), .spr_x(spr_x), .spr_y(spr_y),
        .bmap_we(bmap_we), .bmap_addr(bmap_addr), .bmap_data(bmap_data),
        .h_sync(o4_hs), .v_sync(o4_vs), .active(o4_act), .pix_x(o4_x), .pix_y(o4_y),
        .pixel_on(o4_pon), .frame_start(o4_fs)
    );

    // Sprite RAM model: nonblocking so the raster model below reads the pre-write row.
    always @(posedge clk) begin
        if (bmap_we) m_ram[bmap_addr] <= bmap_data;
    end

    // Raster model for the CLK_DIV=1 instance: one expected output tuple per clk.
    always @(posedge clk or negedge rst_n) begin : raster_model
        exp_t e;
        int   dx, dy;
        logic fr;
        if (!rst_n) begin
            m_h = 0; m_v = 0; m_sx = 0; m_sy = 0;
            sb_q.delete();
        end else begin
            fr = (m_h == 0) && (m_v == 0);
            if (fr) begin
                m_sx = int'(spr_x);
                m_sy = int'(spr_y);
            end
            e.x   = 8'(m_h);
            e.y   = 8'(m_v);
            e.hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            e.vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            e.act = (m_h < HA) && (m_v < VA);
            e.fs  = fr;
            dx    = m_h - m_sx;
            dy    = m_v - m_sy;
            e.pon = 1'b0;
            if (e.act && dx >= 0 && dx < SW && dy >= 0 && dy < SH) e.pon = m_ram[dy][dx];
            sb_q.push_back(e);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    end

    task automatic write_row(input int r, input logic [7:0] d);
        bmap_we   = 1'b1;
        bmap_addr = 2'(r);
        bmap_data = d;
        @(negedge clk);
        bmap_we   = 1'b0;
    endtask

    task automatic test_reset;
        exp_t rst_e, got;
        rst_e = {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int r = 0; r < SH; r++) write_row(r, 8'h00);
        got = {o1_x, o1_y, o1_hs, o1_vs, o1_act, o1_pon, o1_fs};
        checks++;
        if (got !== rst_e) begin
            errors++; $display("FAIL reset_div1: got=%h expected=%h", got, rst_e);
        end
        got = {o4_x, o4_y, o4_hs, o4_vs, o4_act, o4_pon, o4_fs};
        checks++;
        if (got !== rst_e) begin
            errors++; $display("FAIL reset_div4: got=%h expected=%h", got, rst_e);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (o1_fs !== 1'b1 || o1_x !== 8'd0 || o1_y !== 8'd0) begin
                    errors++;
                    $display("FAIL first_fs_div1: fs=%b x=%0d y=%0d expected fs=1 at (0,0)", o1_fs, o1_x, o1_y);
                end
            end
            checks++;
            if (o4_fs !== (k == 4)) begin
                errors++; $display("FAIL first_fs_div4: clk %0d after release fs=%b expected %b", k, o4_fs, k == 4);
            end
        end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_timing;
        exp_t e, got;
        int last_hf = -1, hs_run = 0, last_vf = -1, last_fs = -1;
        logic p_hs, p_vs;
        while (sb_q.size() > 1) void'(sb_q.pop_front());
        p_hs = o1_hs; p_vs = o1_vs;
        for (int c = 0; c < 2 * FR + 100; c++) begin
            got = {o1_x, o1_y, o1_hs, o1_vs, o1_act, o1_pon, o1_fs};
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sb_timing: no expected entry at clk %0d", c);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL sb_timing: got=%h expected=%h (x=%0d y=%0d)", got, e, e.x, e.y);
                end
            end
            if (p_hs && !o1_hs) begin
                checks++;
                if (int'(o1_x) != HA + HF || (last_hf >= 0 && c - last_hf != HT)) begin
                    errors++; $display("FAIL hsync_fall: x=%0d gap=%0d expected x=%0d gap=%0d", o1_x, c - last_hf, HA + HF, HT);
                end
                last_hf = c; hs_run = 0;
            end
            if (!o1_hs) hs_run++;
            if (!p_hs && o1_hs && last_hf >= 0) begin
                checks++;
                if (hs_run != HS || int'(o1_x) != HA + HF + HS) begin
                    errors++; $display("FAIL hsync_width: low=%0d ended at x=%0d expected %0d ending at %0d", hs_run, o1_x, HS, HA + HF + HS);
                end
            end
            if (p_vs != o1_vs) begin
                checks++;
                if (o1_x !== 8'd0 || int'(o1_y) != (o1_vs ? VA + VF + VS : VA + VF)) begin
                    errors++; $display("FAIL vsync_edge: vs=%b at (%0d,%0d) expected x=0 y=%0d", o1_vs, o1_x, o1_y, o1_vs ? VA + VF + VS : VA + VF);
                end
                if (!o1_vs) last_vf = c;
                else if (last_vf >= 0) begin
                    checks++;
                    if (c - last_vf != VS * HT) begin
                        errors++; $display("FAIL vsync_width: low %0d clks expected %0d", c - last_vf, VS * HT);
                    end
                end
            end
            if (o1_fs === 1'b1) begin
                checks++;
                if (o1_x !== 8'd0 || o1_y !== 8'd0 || (last_fs >= 0 && c - last_fs != FR)) begin
                    errors++; $display("FAIL frame_period: at (%0d,%0d) period %0d expected (0,0) period %0d", o1_x, o1_y, c - last_fs, FR);
                end
                last_fs = c;
            end
            p_hs = o1_hs; p_vs = o1_vs;
            @(negedge clk);
        end
        $display("test_timing: done, errors so far %0d", errors);
    endtask

    task automatic test_sprite;
        exp_t e, got;
        int hits[3];
        int ex;
        hits = '{0, 0, 0};
        write_row(0, 8'h01);
        spr_x = 8'd10; spr_y = 8'd5;
        @(negedge clk);
        for (int k = 0; k < FR + 10 && o1_fs !== 1'b1; k++) @(negedge clk);
        checks++;
        if (o1_fs !== 1'b1) begin
            errors++; $display("FAIL sprite_wait_fs: frame_start=%b expected 1 within a frame", o1_fs);
        end
        while (sb_q.size() > 1) void'(sb_q.pop_front());
        for (int c = 0; c < 3 * FR; c++) begin
            got = {o1_x, o1_y, o1_hs, o1_vs, o1_act, o1_pon, o1_fs};
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sb_sprite: no expected entry at clk %0d", c);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL sb_sprite: got=%h expected=%h (x=%0d y=%0d)", got, e, e.x, e.y);
                end
            end
            if (o1_pon === 1'b1) begin
                ex = (c / FR < 2) ? 10 : 20;
                hits[c / FR]++;
                checks++;
                if (int'(o1_x) != ex || o1_y !== 8'd5) begin
                    errors++; $display("FAIL sprite_pos: hit at (%0d,%0d) expected (%0d,5)", o1_x, o1_y, ex);
                end
            end
            if (c == FR + 2 * HT) spr_x = 8'd20;
            @(negedge clk);
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (hits[f] != 1) begin
                errors++; $display("FAIL sprite_count: frame %0d has %0d hits expected 1", f, hits[f]);
            end
        end
        $display("test_sprite: hits per frame %0d %0d %0d", hits[0], hits[1], hits[2]);
    endtask

    task automatic test_clip;
        exp_t e, got;
        int hits[3];
        int f;
        hits = '{0, 0, 0};
        for (int r = 0; r < SH; r++) write_row(r, 8'hFF);
        spr_x = 8'd60; spr_y = 8'd46;
        @(negedge clk);
        for (int k = 0; k < FR + 10 && o1_fs !== 1'b1; k++) @(negedge clk);
        checks++;
        if (o1_fs !== 1'b1) begin
            errors++; $display("FAIL clip_wait_fs: frame_start=%b expected 1 within a frame", o1_fs);
        end
        while (sb_q.size() > 1) void'(sb_q.pop_front());
        for (int c = 0; c < 3 * FR; c++) begin
            f = c / FR;
            got = {o1_x, o1_y, o1_hs, o1_vs, o1_act, o1_pon, o1_fs};
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sb_clip: no expected entry at clk %0d", c);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL sb_clip: got=%h expected=%h (x=%0d y=%0d)", got, e, e.x, e.y);
                end
            end
            if (o1_pon === 1'b1) begin
                hits[f]++;
                checks++;
                if (f != 0 || o1_x < 8'd60 || o1_x > 8'd63 || o1_y < 8'd46 || o1_y > 8'd47) begin
                    errors++; $display("FAIL clip_pos: frame %0d hit at (%0d,%0d) expected only x 60..63 y 46..47 in frame 0", f, o1_x, o1_y);
                end
            end
            // Positions whose window would wrap through 0 if subtraction were not range-checked.
            if (c == 100) begin spr_x = 8'd252; spr_y = 8'd10; end
            if (c == FR + 100) begin spr_x = 8'd2; spr_y = 8'd253; end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hits[k] != (k == 0 ? 8 : 0)) begin
                errors++; $display("FAIL clip_count: frame %0d has %0d hits expected %0d", k, hits[k], k == 0 ? 8 : 0);
            end
        end
        $display("test_clip: hits per frame %0d %0d %0d", hits[0], hits[1], hits[2]);
    endtask

    task automatic test_clkdiv;
        logic p_hs;
        int   last_fall = 0, last_xchg = 0;
        logic [7:0] px;
        bit   found = 0;
        p_hs = o4_hs;
        for (int k = 0; k < 4 * HT + 10 && !found; k++) begin
            @(negedge clk);
            found = p_hs && !o4_hs;
            p_hs  = o4_hs;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL div4_wait_hsync: no h_sync fall seen, expected one per %0d clks", 4 * HT);
        end
        px = o4_x;
        for (int c = 1; c <= 8 * HT; c++) begin
            @(negedge clk);
            if (o4_x !== px) begin
                checks++;
                if (c - last_xchg != 4) begin
                    errors++; $display("FAIL div4_xstep: pix_x changed after %0d clks expected 4", c - last_xchg);
                end
                last_xchg = c; px = o4_x;
            end
            if (p_hs && !o4_hs) begin
                checks++;
                if (c - last_fall != 4 * HT) begin
                    errors++; $display("FAIL div4_line: line length %0d clks expected %0d", c - last_fall, 4 * HT);
                end
                last_fall = c;
            end
            p_hs = o4_hs;
        end
        for (int k = 0; k < 4 * FR + 10 && o4_fs !== 1'b1; k++) @(negedge clk);
        checks++;
        if (o4_fs !== 1'b1 || o4_x !== 8'd0 || o4_y !== 8'd0) begin
            errors++; $display("FAIL div4_fs: fs=%b at (%0d,%0d) expected 1 at (0,0)", o4_fs, o4_x, o4_y);
        end
        @(negedge clk);
        checks++;
        if (o4_fs !== 1'b0) begin
            errors++; $display("FAIL div4_fs_width: fs=%b one clk later expected 0", o4_fs);
        end
        $display("test_clkdiv: done, errors so far %0d", errors);
    endtask

    task automatic test_reset_midline;
        exp_t e, got, rst_e;
        rst_e = {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < HT + 10 && o1_x !== 8'd30; k++) @(negedge clk);
        checks++;
        if (o1_x !== 8'd30) begin
            errors++; $display("FAIL midrst_wait: pix_x=%0d expected 30", o1_x);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        got = {o1_x, o1_y, o1_hs, o1_vs, o1_act, o1_pon, o1_fs};
        checks++;
        if (got !== rst_e) begin
            errors++; $display("FAIL midrst_div1: got=%h expected=%h", got, rst_e);
        end
        got = {o4_x, o4_y, o4_hs, o4_vs, o4_act, o4_pon, o4_fs};
        checks++;
        if (got !== rst_e) begin
            errors++; $display("FAIL midrst_div4: got=%h expected=%h", got, rst_e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o1_fs !== 1'b1 || o1_x !== 8'd0 || o1_y !== 8'd0) begin
            errors++; $display("FAIL midrst_fs: fs=%b at (%0d,%0d) expected 1 at (0,0)", o1_fs, o1_x, o1_y);
        end
        while (sb_q.size() > 1) void'(sb_q.pop_front());
        for (int c = 0; c < 3 * HT; c++) begin
            got = {o1_x, o1_y, o1_hs, o1_vs, o1_act, o1_pon, o1_fs};
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sb_midrst: no expected entry at clk %0d", c);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL sb_midrst: got=%h expected=%h (x=%0d y=%0d)", got, e, e.x, e.y);
                end
            end
            @(negedge clk);
        end
        $display("test_reset_midline: done, errors so far %0d", errors);
    endtask

    initial begin
        test_reset();
        test_timing();
        test_sprite();
        test_clip();
        test_clkdiv();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
